ad7606_emu: RTL

Synthesizable AD7606 responder model, clocked at clk_25. It gives the ADC controller a closed loop for on-board self-test and simulation with no real converter attached.
- Watches the controller's CONVST, CS_n and RD_n pins.
- Drives BUSY for a fixed conversion time.
- Returns 8 channel-tagged 16-bit samples on the parallel DB bus, one word per RD_n falling edge, with FRSTDATA marking channel 0.

---
 rtl/ad7606_pkg.sv | 15 +
 rtl/ad7606_emu_sync_edge.sv | 39 +++
 rtl/ad7606_emu.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ad7606_pkg.sv
// Shared constants and FSM encoding for the AD7606 responder model.
// Default conversion time, channel count and tag width live here.
package ad7606_pkg;

    localparam int NCH_MAX         = 8;
    localparam int CONV_CYCLES_DEF = 100;
    localparam int TAG_W_DEF       = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        READ = 2'd2
    } state_e;

endpackage

// File: rtl/ad7606_emu_sync_edge.sv
// Two-flop synchronizer plus an edge-detect flop for one asynchronous pin.
// RST_VAL matches the pin's idle level so no false edge appears after reset.
module sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_25,
    input  logic rst_n,
    input  logic d,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
            s3_q <= RST_VAL;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign lvl  = s2_q;
    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;

endmodule

// File: rtl/ad7606_emu.sv
// AD7606 responder: answers CONVST with a timed BUSY pulse, then serves
// NCH channel-tagged samples on DB, one per qualified RD_n falling edge.
module ad7606_emu
    import ad7606_pkg::*;
#(
    parameter int CONV_CYCLES = CONV_CYCLES_DEF,
    parameter int NCH         = NCH_MAX,
    parameter int TAG_W       = TAG_W_DEF
) (
    input  logic        clk_25,
    input  logic        rst_n,
    input  logic        convst,
    input  logic        cs_n,
    input  logic        rd_n,
    output logic        busy,
    output logic        frstdata,
    output logic [15:0] db,
    output logic        db_oe,
    output logic        ovr
);

    localparam int         CNT_W    = 16 - TAG_W;
    localparam logic [2:0] LAST_IDX = 3'(NCH - 1);

    logic conv_lvl, conv_rise, conv_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic rd_lvl, rd_rise, rd_fall_raw;
    logic rd_fall;
    logic unused_sync;

    sync_edge #(.RST_VAL(1'b0)) u_sync_conv (
        .clk_25(clk_25), .rst_n(rst_n), .d(convst),
        .lvl(conv_lvl), .rise(conv_rise), .fall(conv_fall)
    );
    sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
        .clk_25(clk_25), .rst_n(rst_n), .d(cs_n),
        .lvl(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );
    sync_edge #(.RST_VAL(1'b1)) u_sync_rd (
        .clk_25(clk_25), .rst_n(rst_n), .d(rd_n),
        .lvl(rd_lvl), .rise(rd_rise), .fall(rd_fall_raw)
    );

    assign unused_sync = ^{conv_lvl, conv_fall, cs_rise, cs_fall, rd_lvl, rd_rise};
    assign rd_fall     = rd_fall_raw & ~cs_lvl;

    state_e           state_q, state_d;
    logic             busy_q, busy_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [2:0]       rd_idx_q, rd_idx_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0] snap_q, snap_d;
    logic [15:0]      db_q, db_d;
    logic             frst_q, frst_d;
    logic             oe_q, oe_d;
    logic             ovr_q, ovr_d;

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            cnt_q        <= '0;
            rd_idx_q     <= '0;
            sample_cnt_q <= '0;
            snap_q       <= '0;
            db_q         <= '0;
            frst_q       <= 1'b0;
            oe_q         <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            cnt_q        <= cnt_d;
            rd_idx_q     <= rd_idx_d;
            sample_cnt_q <= sample_cnt_d;
            snap_q       <= snap_d;
            db_q         <= db_d;
            frst_q       <= frst_d;
            oe_q         <= oe_d;
            ovr_q        <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (conv_rise) state_d = CONV;
            CONV: if (cnt_q == 8'd0) state_d = READ;
            READ: begin
                if (conv_rise)                          state_d = CONV;
                else if (rd_fall && rd_idx_q == LAST_IDX) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Only the sample counter is snapshotted; the channel tag is appended on read.
    always_comb begin
        busy_d       = busy_q;
        cnt_d        = cnt_q;
        rd_idx_d     = rd_idx_q;
        sample_cnt_d = sample_cnt_q;
        snap_d       = snap_q;
        db_d         = db_q;
        frst_d       = frst_q;
        oe_d         = ~cs_lvl;
        ovr_d        = ovr_q;
        case (state_q)
            IDLE: begin
                if (conv_rise) begin
                    busy_d       = 1'b1;
                    cnt_d        = 8'(CONV_CYCLES - 1);
                    snap_d       = sample_cnt_q;
                    sample_cnt_d = sample_cnt_q + CNT_W'(1);
                    rd_idx_d     = '0;
                end else if (rd_fall) begin
                    db_d   = '0;
                    frst_d = 1'b0;
                end
            end
            CONV: begin
                if (conv_rise || rd_fall) ovr_d = 1'b1;
                if (cnt_q == 8'd0) begin
                    busy_d   = 1'b0;
                    rd_idx_d = '0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            READ: begin
                if (conv_rise) begin
                    busy_d       = 1'b1;
                    cnt_d        = 8'(CONV_CYCLES - 1);
                    snap_d       = sample_cnt_q;
                    sample_cnt_d = sample_cnt_q + CNT_W'(1);
                    rd_idx_d     = '0;
                    if (rd_idx_q == 3'd0) ovr_d = 1'b1;
                end else if (rd_fall) begin
                    db_d     = {TAG_W'(rd_idx_q), snap_q};
                    frst_d   = (rd_idx_q == 3'd0);
                    rd_idx_d = (rd_idx_q == LAST_IDX) ? 3'd0 : rd_idx_q + 3'd1;
                end
            end
            default: ;
        endcase
    end

    assign busy     = busy_q;
    assign frstdata = frst_q;
    assign db       = db_q;
    assign db_oe    = oe_q;
    assign ovr      = ovr_q;

endmodule
